invz_bus_arb: RTL
=================

INVZ_BUS_ARB -- requirements
Module: invz_bus_arb

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel and width of the shared output bus.
REQ-002 Parameter NCH, default 4 (range 2..16): number of requesting channels.
REQ-003 Parameter INVERT, default 1: 1 drives ZN = ~I of the owner; 0 drives ZN = I (buffer mode).
REQ-004 Parameter DEAD, default 1 (range 0..7): turnaround cycles with ZN high-Z between owners.
REQ-005 Parameter HOLD_MAX, default 16 (0 = unlimited): maximum consecutive DRIVE cycles while another channel requests.
REQ-006 CLK  input  1  rising-edge clock; sole clock.
REQ-007 RN  input  1  reset; asynchronous assert, active-low.
REQ-008 REQ  input  NCH  per-channel bus request, level-sensitive.
REQ-009 I  input  NCH*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 GNT  output  NCH  registered one-hot grant; all-zero when no owner.
REQ-011 OE  output  1  registered; high exactly when ZN is driven.
REQ-012 ZN  output  WIDTH  tri-state bus; high-Z whenever OE is low.
REQ-013 VDD, VSS  inout  1  power pins; no functional role.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE and TURN.
REQ-015 In IDLE with any REQ high at a rising edge, the block SHALL select the winner by round-robin starting at pointer PTR, and set GNT[winner]=1, OE=1 and state DRIVE at that edge.
REQ-016 In IDLE with REQ all-zero, GNT, OE and state SHALL remain unchanged.
REQ-017 When OE=1, ZN SHALL equal ~I[owner] (INVERT=1) or I[owner] (INVERT=0), combinationally from I with no register stage.
REQ-018 On every grant, PTR SHALL load (winner+1) mod NCH.
REQ-019 In DRIVE, the owner SHALL retain the grant while its REQ stays high, subject to REQ-021.
REQ-020 In DRIVE, if the owner's REQ is low at an edge, GNT SHALL clear and OE SHALL fall at that edge; state SHALL go to TURN when DEAD>0, else IDLE.
REQ-021 With HOLD_MAX>0, HOLD_CNT SHALL count DRIVE cycles; when HOLD_CNT reaches HOLD_MAX while any other REQ is high, the owner SHALL be released as in REQ-020 even with its REQ high.
REQ-022 HOLD_CNT SHALL clear on every grant and saturate at HOLD_MAX; with no competing request it SHALL not force release.
REQ-023 TURN SHALL last exactly DEAD cycles with OE=0 and GNT all-zero, then go to IDLE.
REQ-024 Minimum bus-idle time between two owners SHALL be DEAD+1 cycles; two GNT bits SHALL never be high in the same cycle.
REQ-025 A released owner whose REQ remains high SHALL re-enter arbitration under normal round-robin order.
REQ-026 REQ changes during TURN SHALL be ignored until IDLE.

Reset
REQ-027 While RN=0: GNT=0, OE=0, ZN high-Z, state IDLE, PTR=0, HOLD_CNT=0, all applied asynchronously, including mid-DRIVE.
REQ-028 After RN rises, the first grant SHALL occur no earlier than the first rising edge with RN=1.

Structure
REQ-029 Package invz_bus_pkg SHALL hold the state enum (IDLE, DRIVE, TURN) and the parameter defaults.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (inputs REQ, PTR; outputs one-hot winner and valid); the FSM, counters and tri-state driver SHALL stay in invz_bus_arb.

Verification
REQ-031 Reset, REQ=4'b0000, I arbitrary -> GNT=0, OE=0, ZN=8'hzz indefinitely.
REQ-032 INVERT=1, REQ[2]=1 only, I[2]=8'h3C -> one edge later GNT=4'b0100, OE=1, ZN=8'hC3; with INVERT=0, ZN=8'h3C.
REQ-033 REQ=4'b1111 held, HOLD_MAX=4, DEAD=1 -> grant order ch0,ch1,ch2,ch3,ch0; each DRIVE 4 cycles; 2 high-Z cycles between owners.
REQ-034 DEAD=0, ch1 drops REQ while ch3 requests -> OE low exactly 1 cycle, then GNT=4'b1000.
REQ-035 RN pulled low mid-DRIVE between clock edges -> ZN high-Z and GNT=0 immediately; after release the first grant goes to ch0 (PTR=0).
REQ-036 HOLD_MAX=0, REQ[0] held 100 cycles with REQ[1] high -> ch0 keeps the grant all 100 cycles; no second GNT bit ever asserted.

Source files
------------

// File: rtl/invz_bus_pkg.sv
// Shared types and defaults for the inverting tri-state bus arbiter.
package invz_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int WIDTH_DEF    = 8;
  localparam int NCH_DEF      = 4;
  localparam int INVERT_DEF   = 1;
  localparam int DEAD_DEF     = 1;
  localparam int HOLD_MAX_DEF = 16;

  // One-hot (up to 16 bits) to binary index; zero when no bit is set.
  function automatic logic [3:0] oh2idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/invz_bus_arb_rr_pick.sv
// Round-robin picker: first requesting channel at or after ptr_i, wrapping.
module rr_pick #(
  parameter int NCH = 4,
  parameter int PW  = 2
) (
  input  logic [NCH-1:0] req_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [NCH-1:0] win_o,
  output logic           valid_o
);

  logic [PW:0] idx;

  // Walk from the farthest candidate back to ptr_i so the nearest one wins.
  always_comb begin
    win_o = '0;
    idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_i} + (PW+1)'(i);
      if (idx >= (PW+1)'(NCH)) idx = idx - (PW+1)'(NCH);
      if (req_i[idx[PW-1:0]]) begin
        win_o = '0;
        win_o[idx[PW-1:0]] = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/invz_bus_arb.sv
// Round-robin arbiter driving one shared tri-state bus, with hold limit and
// dead-time turnaround between owners.
module invz_bus_arb
  import invz_bus_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NCH      = NCH_DEF,
  parameter int INVERT   = INVERT_DEF,
  parameter int DEAD     = DEAD_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic [NCH-1:0]       REQ,
  input  logic [NCH*WIDTH-1:0] I,
  output logic [NCH-1:0]       GNT,
  output logic                 OE,
  output wire  [WIDTH-1:0]     ZN,
  inout  wire                  VDD,
  inout  wire                  VSS,
  output state_t               dbg_state_o
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [2:0]    DEAD_LAST = 3'((DEAD > 0) ? DEAD - 1 : 0);

  state_t         state_q, state_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic           oe_q, oe_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [2:0]     turn_q, turn_d;

  logic [NCH-1:0] pick_win;
  logic           pick_valid;
  logic [PW-1:0]  win_idx, owner_idx;
  logic           owner_req, others_req, force_rel, release_now;
  logic [WIDTH-1:0] own_data;
  wire            unused_pwr;

  assign unused_pwr = VDD ^ VSS;

  rr_pick #(.NCH(NCH), .PW(PW)) u_pick (
    .req_i  (REQ),
    .ptr_i  (ptr_q),
    .win_o  (pick_win),
    .valid_o(pick_valid)
  );

  // REQ is a level request; a channel owns the bus from the edge that sets
  // its GNT bit until the edge that clears it, and must keep REQ high to stay.
  assign win_idx     = PW'(oh2idx(16'(pick_win)));
  assign owner_idx   = PW'(oh2idx(16'(gnt_q)));
  assign owner_req   = |(REQ & gnt_q);
  assign others_req  = |(REQ & ~gnt_q);
  assign force_rel   = (HOLD_MAX != 0) && others_req && (hold_q >= HOLD_LAST);
  assign release_now = !owner_req || force_rel;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = DRIVE;
      DRIVE:   if (release_now) state_d = (DEAD > 0) ? TURN : IDLE;
      TURN:    if (turn_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = gnt_q;
    oe_d   = oe_q;
    ptr_d  = ptr_q;
    hold_d = hold_q;
    turn_d = turn_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d  = pick_win;
          oe_d   = 1'b1;
          ptr_d  = (win_idx == PW'(NCH - 1)) ? '0 : win_idx + 1'b1;
          hold_d = '0;
        end
      end
      DRIVE: begin
        if (release_now) begin
          gnt_d  = '0;
          oe_d   = 1'b0;
          hold_d = '0;
          turn_d = DEAD_LAST;
        end else if ((HOLD_MAX != 0) && (hold_q < HOLD_SAT)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      TURN: begin
        if (turn_q != '0) turn_d = turn_q - 1'b1;
      end
      default: begin
        gnt_d = '0;
        oe_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      gnt_q  <= '0;
      oe_q   <= 1'b0;
      ptr_q  <= '0;
      hold_q <= '0;
      turn_q <= '0;
    end else begin
      gnt_q  <= gnt_d;
      oe_q   <= oe_d;
      ptr_q  <= ptr_d;
      hold_q <= hold_d;
      turn_q <= turn_d;
    end
  end

  assign own_data    = I[owner_idx*WIDTH +: WIDTH];
  assign ZN          = oe_q ? ((INVERT != 0) ? ~own_data : own_data) : {WIDTH{1'bz}};
  assign GNT         = gnt_q;
  assign OE          = oe_q;
  assign dbg_state_o = state_q;

endmodule
